// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Arbitrates a fetch port and a load/store port onto one single-port memory bus.
// At most one bus transaction is outstanding. The memory stage wins simultaneous
// requests. On an ack, the other pending requester can be granted directly, so
// bus_req_o stays high across back-to-back transactions.
//
// Ports
//   clk_i, rst_i             clock, asynchronous active-high reset
//   start_i                  arbitration enable (no new grants while low)
//   if_req_i/if_addr_i       fetch request; if_rdata_o/if_valid_o completion
//   mem_req_i/mem_we_i/...   load/store request; mem_rdata_o/mem_valid_o completion
//   bus_*_o / bus_ack_i/...  registered memory request, one-cycle ack with read data
//   if_stall_o/mem_stall_o   stalls to the fetch / memory stage
//   if_stall_cnt_o/...       saturating stall counters (only with ARB_PERF_CNT_EN)
//
// Configuration macro: ARB_PERF_CNT_EN enables the stall counters and their ports.
module mem_port_arbiter #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic [DATA_W-1:0] if_rdata_o,
   output logic              if_valid_o,
   input  logic              mem_req_i,
   input  logic              mem_we_i,
   input  logic [ADDR_W-1:0] mem_addr_i,
   input  logic [DATA_W-1:0] mem_wdata_i,
   output logic [DATA_W-1:0] mem_rdata_o,
   output logic              mem_valid_o,
   output logic              bus_req_o,
   output logic              bus_we_o,
   output logic [ADDR_W-1:0] bus_addr_o,
   output logic [DATA_W-1:0] bus_wdata_o,
   input  logic              bus_ack_i,
   input  logic [DATA_W-1:0] bus_rdata_i,
`ifdef ARB_PERF_CNT_EN
   output logic [CNT_W-1:0]  if_stall_cnt_o,
   output logic [CNT_W-1:0]  mem_stall_cnt_o,
`endif
   output logic              if_stall_o,
   output logic              mem_stall_o
);

   localparam logic [1:0] StIdle    = 2'd0;
   localparam logic [1:0] StBusyIf  = 2'd1;
   localparam logic [1:0] StBusyMem = 2'd2;

   logic [1:0]        state_q, state_d;
   logic              bus_req_q, bus_req_d;
   logic              bus_we_q, bus_we_d;
   logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
   logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
   logic              if_valid_q, if_valid_d;
   logic              mem_valid_q, mem_valid_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;

   logic if_pend, mem_pend;
   logic grant_if, grant_mem;

   // A requester still holds its req during its valid cycle; mask it so the
   // completed transaction is not granted a second time.
   assign if_pend  = if_req_i  & ~if_valid_q;
   assign mem_pend = mem_req_i & ~mem_valid_q;

   always_comb begin
      state_d     = state_q;
      bus_req_d   = bus_req_q;
      bus_we_d    = bus_we_q;
      bus_addr_d  = bus_addr_q;
      bus_wdata_d = bus_wdata_q;
      if_valid_d  = 1'b0;
      mem_valid_d = 1'b0;
      if_rdata_d  = if_rdata_q;
      mem_rdata_d = mem_rdata_q;
      grant_if    = 1'b0;
      grant_mem   = 1'b0;

      case (state_q)
         StIdle: begin
            if (start_i) begin
               if (mem_pend) begin
                  grant_mem = 1'b1;
               end else if (if_pend) begin
                  grant_if = 1'b1;
               end
            end
         end
         StBusyIf: begin
            if (bus_ack_i) begin
               if_valid_d = 1'b1;
               if_rdata_d = bus_rdata_i;
               if (start_i && mem_pend) begin
                  grant_mem = 1'b1;
               end else begin
                  state_d   = StIdle;
                  bus_req_d = 1'b0;
               end
            end
         end
         StBusyMem: begin
            if (bus_ack_i) begin
               mem_valid_d = 1'b1;
               // Stores leave the last load data visible.
               if (!bus_we_q) begin
                  mem_rdata_d = bus_rdata_i;
               end
               if (start_i && if_pend) begin
                  grant_if = 1'b1;
               end else begin
                  state_d   = StIdle;
                  bus_req_d = 1'b0;
               end
            end
         end
         default: begin
            state_d   = StIdle;
            bus_req_d = 1'b0;
         end
      endcase

      if (grant_mem) begin
         state_d     = StBusyMem;
         bus_req_d   = 1'b1;
         bus_we_d    = mem_we_i;
         bus_addr_d  = mem_addr_i;
         bus_wdata_d = mem_wdata_i;
      end else if (grant_if) begin
         state_d     = StBusyIf;
         bus_req_d   = 1'b1;
         bus_we_d    = 1'b0;
         bus_addr_d  = if_addr_i;
         bus_wdata_d = '0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= StIdle;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= '0;
         bus_wdata_q <= '0;
         if_valid_q  <= 1'b0;
         mem_valid_q <= 1'b0;
         if_rdata_q  <= '0;
         mem_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         bus_req_q   <= bus_req_d;
         bus_we_q    <= bus_we_d;
         bus_addr_q  <= bus_addr_d;
         bus_wdata_q <= bus_wdata_d;
         if_valid_q  <= if_valid_d;
         mem_valid_q <= mem_valid_d;
         if_rdata_q  <= if_rdata_d;
         mem_rdata_q <= mem_rdata_d;
      end
   end

   assign bus_req_o   = bus_req_q;
   assign bus_we_o    = bus_we_q;
   assign bus_addr_o  = bus_addr_q;
   assign bus_wdata_o = bus_wdata_q;
   assign if_valid_o  = if_valid_q;
   assign mem_valid_o = mem_valid_q;
   assign if_rdata_o  = if_rdata_q;
   assign mem_rdata_o = mem_rdata_q;

   assign if_stall_o  = if_req_i & ~if_valid_q;
   assign mem_stall_o = mem_req_i & ~mem_valid_q;

`ifdef ARB_PERF_CNT_EN
   logic [CNT_W-1:0] if_cnt_q, if_cnt_d;
   logic [CNT_W-1:0] mem_cnt_q, mem_cnt_d;

   // Saturating counters: stop at all-ones instead of wrapping.
   always_comb begin
      if_cnt_d  = if_cnt_q;
      mem_cnt_d = mem_cnt_q;
      if (if_stall_o && (if_cnt_q != '1)) begin
         if_cnt_d = if_cnt_q + 1'b1;
      end
      if (mem_stall_o && (mem_cnt_q != '1)) begin
         mem_cnt_d = mem_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         if_cnt_q  <= '0;
         mem_cnt_q <= '0;
      end else begin
         if_cnt_q  <= if_cnt_d;
         mem_cnt_q <= mem_cnt_d;
      end
   end

   assign if_stall_cnt_o  = if_cnt_q;
   assign mem_stall_cnt_o = mem_cnt_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter. Inputs change and outputs are sampled
// 1 time unit after each rising edge. Counter checks apply when ARB_PERF_CNT_EN
// is defined.
module tb_mem_port_arbiter;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned CNT_W  = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic [DATA_W-1:0] if_rdata;
   logic              if_valid;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_valid;
   logic              bus_req;
   logic              bus_we;
   logic [ADDR_W-1:0] bus_addr;
   logic [DATA_W-1:0] bus_wdata;
   logic              bus_ack;
   logic [DATA_W-1:0] bus_rdata;
   logic              if_stall;
   logic              mem_stall;
`ifdef ARB_PERF_CNT_EN
   logic [CNT_W-1:0]  if_cnt;
   logic [CNT_W-1:0]  mem_cnt;
`endif

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W),
      .CNT_W (CNT_W)
   ) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .start_i        (start),
      .if_req_i       (if_req),
      .if_addr_i      (if_addr),
      .if_rdata_o     (if_rdata),
      .if_valid_o     (if_valid),
      .mem_req_i      (mem_req),
      .mem_we_i       (mem_we),
      .mem_addr_i     (mem_addr),
      .mem_wdata_i    (mem_wdata),
      .mem_rdata_o    (mem_rdata),
      .mem_valid_o    (mem_valid),
      .bus_req_o      (bus_req),
      .bus_we_o       (bus_we),
      .bus_addr_o     (bus_addr),
      .bus_wdata_o    (bus_wdata),
      .bus_ack_i      (bus_ack),
      .bus_rdata_i    (bus_rdata),
`ifdef ARB_PERF_CNT_EN
      .if_stall_cnt_o (if_cnt),
      .mem_stall_cnt_o(mem_cnt),
`endif
      .if_stall_o     (if_stall),
      .mem_stall_o    (mem_stall)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; if_req = 1'b0; if_addr = '0; mem_req = 1'b0;
      mem_we = 1'b0; mem_addr = '0; mem_wdata = '0; bus_ack = 1'b0; bus_rdata = '0;
      tick();
      tick();
      n_cmp++; if (bus_req !== 1'b0) begin n_fail++; $display("FAIL rst_bus_req: got %h want 0", bus_req); end
      n_cmp++; if (bus_we !== 1'b0) begin n_fail++; $display("FAIL rst_bus_we: got %h want 0", bus_we); end
      n_cmp++; if (bus_addr !== 32'h0) begin n_fail++; $display("FAIL rst_bus_addr: got %h want 0", bus_addr); end
      n_cmp++; if (bus_wdata !== 32'h0) begin n_fail++; $display("FAIL rst_bus_wdata: got %h want 0", bus_wdata); end
      n_cmp++; if ({if_valid, mem_valid} !== 2'b00) begin n_fail++; $display("FAIL rst_valid: got %b want 00", {if_valid, mem_valid}); end
      n_cmp++; if (if_rdata !== 32'h0 || mem_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %h/%h want 0/0", if_rdata, mem_rdata); end
`ifdef ARB_PERF_CNT_EN
      n_cmp++; if (if_cnt !== 4'd0 || mem_cnt !== 4'd0) begin n_fail++; $display("FAIL rst_cnt: got %0d/%0d want 0/0", if_cnt, mem_cnt); end
`endif
      rst = 1'b0;
      tick();
      // Ack while idle must be ignored.
      bus_ack = 1'b1; bus_rdata = 32'hDEAD;
      tick();
      bus_ack = 1'b0;
      n_cmp++; if (bus_req !== 1'b0 || mem_valid !== 1'b0 || if_valid !== 1'b0 || mem_rdata !== 32'h0 || if_rdata !== 32'h0) begin
         n_fail++; $display("FAIL idle_ack: got req=%b mv=%b iv=%b md=%h id=%h want all 0", bus_req, mem_valid, if_valid, mem_rdata, if_rdata);
      end
   endtask

   task automatic test_single_load();
      int stall_cycles = 0;
      start = 1'b1; mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h4;
      #1 if (mem_stall) stall_cycles++;
      tick();
      n_cmp++; if (bus_req !== 1'b1 || bus_addr !== 32'h4 || bus_we !== 1'b0) begin
         n_fail++; $display("FAIL load_req: got req=%b addr=%h we=%b want 1/4/0", bus_req, bus_addr, bus_we);
      end
      if (mem_stall) stall_cycles++;
      bus_ack = 1'b1; bus_rdata = 32'h5;
      tick();
      bus_ack = 1'b0;
      n_cmp++; if (mem_valid !== 1'b1 || mem_rdata !== 32'h5) begin
         n_fail++; $display("FAIL load_done: got valid=%b rdata=%h want 1/5", mem_valid, mem_rdata);
      end
      n_cmp++; if (bus_req !== 1'b0) begin n_fail++; $display("FAIL load_req_drop: got %b want 0", bus_req); end
      if (mem_stall) stall_cycles++;
      n_cmp++; if (stall_cycles !== 2) begin n_fail++; $display("FAIL load_stall_len: got %0d want 2", stall_cycles); end
      mem_req = 1'b0;
      tick();
      n_cmp++; if (mem_valid !== 1'b0 || bus_req !== 1'b0) begin
         n_fail++; $display("FAIL load_pulse: got valid=%b req=%b want 0/0", mem_valid, bus_req);
      end
   endtask

   task automatic test_back_to_back();
      if_req = 1'b1; if_addr = 32'h10; mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h0;
      tick();
      n_cmp++; if (bus_req !== 1'b1 || bus_addr !== 32'h0) begin
         n_fail++; $display("FAIL b2b_first: got req=%b addr=%h want 1/0", bus_req, bus_addr);
      end
      bus_ack = 1'b1; bus_rdata = 32'hAA;
      tick();
      n_cmp++; if (bus_req !== 1'b1 || bus_addr !== 32'h10 || bus_we !== 1'b0) begin
         n_fail++; $display("FAIL b2b_second: got req=%b addr=%h we=%b want 1/10/0", bus_req, bus_addr, bus_we);
      end
      n_cmp++; if (mem_valid !== 1'b1 || if_valid !== 1'b0 || mem_rdata !== 32'hAA) begin
         n_fail++; $display("FAIL b2b_mem_valid: got mv=%b iv=%b md=%h want 1/0/aa", mem_valid, if_valid, mem_rdata);
      end
      mem_req = 1'b0; bus_rdata = 32'hBB;
      tick();
      bus_ack = 1'b0;
      n_cmp++; if (if_valid !== 1'b1 || mem_valid !== 1'b0 || if_rdata !== 32'hBB || bus_req !== 1'b0) begin
         n_fail++; $display("FAIL b2b_if_valid: got iv=%b mv=%b id=%h req=%b want 1/0/bb/0", if_valid, mem_valid, if_rdata, bus_req);
      end
      if_req = 1'b0;
      tick();
      n_cmp++; if (if_valid !== 1'b0 || mem_valid !== 1'b0 || bus_req !== 1'b0) begin
         n_fail++; $display("FAIL b2b_once: got iv=%b mv=%b req=%b want 0/0/0", if_valid, mem_valid, bus_req);
      end
   endtask

   task automatic test_store();
      mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h8; mem_wdata = 32'h2A;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_cmp++; if (bus_req !== 1'b1 || bus_we !== 1'b1 || bus_addr !== 32'h8 || bus_wdata !== 32'h2A || mem_valid !== 1'b0) begin
            n_fail++; $display("FAIL store_hold[%0d]: got req=%b we=%b addr=%h wd=%h mv=%b want 1/1/8/2a/0", i, bus_req, bus_we, bus_addr, bus_wdata, mem_valid);
         end
         if (i == 3) begin
            bus_ack = 1'b1; bus_rdata = 32'h77;
         end
      end
      tick();
      bus_ack = 1'b0;
      n_cmp++; if (mem_valid !== 1'b1 || mem_rdata !== 32'hAA || bus_req !== 1'b0) begin
         n_fail++; $display("FAIL store_done: got mv=%b md=%h req=%b want 1/aa/0", mem_valid, mem_rdata, bus_req);
      end
      mem_req = 1'b0; mem_we = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid();
      if_req = 1'b1; if_addr = 32'h20;
      tick();
      n_cmp++; if (bus_req !== 1'b1 || bus_addr !== 32'h20) begin
         n_fail++; $display("FAIL mid_grant: got req=%b addr=%h want 1/20", bus_req, bus_addr);
      end
      rst = 1'b1;
      #1;
      n_cmp++; if (bus_req !== 1'b0 || bus_addr !== 32'h0 || if_rdata !== 32'h0 || mem_rdata !== 32'h0 || if_valid !== 1'b0) begin
         n_fail++; $display("FAIL mid_async_rst: got req=%b addr=%h id=%h md=%h iv=%b want 0/0/0/0/0", bus_req, bus_addr, if_rdata, mem_rdata, if_valid);
      end
      if_req = 1'b0;
      tick();
      rst = 1'b0;
      bus_ack = 1'b1; bus_rdata = 32'h99;
      tick();
      bus_ack = 1'b0;
      n_cmp++; if (if_valid !== 1'b0 || if_rdata !== 32'h0 || bus_req !== 1'b0) begin
         n_fail++; $display("FAIL mid_late_ack: got iv=%b id=%h req=%b want 0/0/0", if_valid, if_rdata, bus_req);
      end
   endtask

   task automatic test_start_gate();
      start = 1'b0; if_req = 1'b1; if_addr = 32'h30;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_cmp++; if (bus_req !== 1'b0 || if_stall !== 1'b1) begin
            n_fail++; $display("FAIL gate_hold[%0d]: got req=%b stall=%b want 0/1", i, bus_req, if_stall);
         end
      end
      start = 1'b1;
      tick();
      n_cmp++; if (bus_req !== 1'b1 || bus_addr !== 32'h30) begin
         n_fail++; $display("FAIL gate_grant: got req=%b addr=%h want 1/30", bus_req, bus_addr);
      end
      // In-flight transaction completes even with start low.
      start = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h31;
      tick();
      bus_ack = 1'b0;
      n_cmp++; if (if_valid !== 1'b1 || if_rdata !== 32'h31 || if_stall !== 1'b0) begin
         n_fail++; $display("FAIL gate_inflight: got iv=%b id=%h stall=%b want 1/31/0", if_valid, if_rdata, if_stall);
      end
      if_req = 1'b0;
      tick();
   endtask

   task automatic test_stall_cnt();
`ifdef ARB_PERF_CNT_EN
      do_reset();
      start = 1'b0; if_req = 1'b1; if_addr = 32'h40;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (i == 5) begin
            n_cmp++; if (if_cnt !== 4'd5) begin n_fail++; $display("FAIL cnt_mid: got %0d want 5", if_cnt); end
         end
      end
      n_cmp++; if (if_cnt !== 4'd15 || mem_cnt !== 4'd0) begin
         n_fail++; $display("FAIL cnt_sat: got if=%0d mem=%0d want 15/0", if_cnt, mem_cnt);
      end
      if_req = 1'b0;
      tick();
`endif
   endtask

   initial begin
      test_reset();
      test_single_load();
      test_back_to_back();
      test_store();
      test_reset_mid();
      test_start_gate();
      test_stall_cnt();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
